maze_game_ctrl: RTL and testbench
=================================

Name: maze_game_ctrl

Overview:
- Game controller that sequences the maze renderer: owns game state (welcome/play/win), player cell position, and the latched maze configuration fed to the pixel drawer.
- Takes raw push-buttons, synchronizes and edge-detects them, and checks each move against bounds and walls.
- Commits moves and detects arrival at the goal cell.
- Sits between board buttons/map source and the draw block on the same vga_clk domain.

Parameters:
- MOVE_GAP, 2500000, cycles after any processed move during which direction edges are ignored (100 ms at 25 MHz; bench uses 8).
- MIN_NUM, 5, smallest accepted maze side length.
- MAX_NUM, 19, largest accepted maze side length.

Ports:
- vga_clk  in  1  system/pixel clock.
- rst_sys  in  1  asynchronous, active-high reset.
- btn_start  in  1  raw start/confirm button.
- btn_up, btn_down, btn_left, btn_right  in  1 each  raw direction buttons.
- num_in  in  5  requested maze side length.
- map_in  in  361  requested map; bit (y*num+x) = 1 means wall.
- state  out  2  0 welcome, 1 play, 2 win; 3 is never driven.
- num  out  5  latched side length to draw.
- map  out  361  latched map to draw.
- x_index, y_index  out  5 each  player cell.
- step_count  out  10  committed moves this game, saturating.
- win_pulse  out  1  one-cycle pulse on entering win.
- bump_pulse  out  1  one-cycle pulse when a move is rejected.

Behaviour:
- Reset (async, any time, including mid-move):
  - state=0, num=0, map=0, x_index=y_index=1, step_count=0, pulses=0, gap counter=0.
  - All synchronizer flops are cleared to 0.
- Input conditioning:
  - Every button passes through a 2-flop synchronizer, then a rising-edge detector on the synchronized value.
  - A held button produces exactly one edge.
- WELCOME (0):
  - On start edge with MIN_NUM <= num_in <= MAX_NUM: latch num_in->num and map_in->map, set x=y=1, step_count=0, go to PLAY next cycle.
  - On start edge with num_in out of range: stay in WELCOME; num/map are unchanged.
  - Direction edges are ignored.
- PLAY (1), move pipeline:
  - Cycle A (direction edge seen, gap counter = 0): register target cell. Priority when edges coincide: up > down > left > right.
  - Target: up y-1, down y+1, left x-1, right x+1.
  - Cycle B (sub-state CHECK): target is legal iff 0 <= tx,ty <= num-1 and map[ty*num+tx] == 0.
    - Legal: commit x/y at the end of B, and step_count+1, saturating at 1023.
    - Illegal: position is unchanged, and bump_pulse=1 in the cycle after B.
  - Net latency: position output changes on the 2nd rising edge after the cycle in which the edge detector fires.
  - Bounds arithmetic: done in 6-bit signed form so that x-1 at x=0 is rejected rather than wrapping. Wall index is 9 bits, max 360.
  - Gap: the gap counter loads MOVE_GAP at the end of B, whether the move was legal or illegal.
  - Direction edges arriving while the counter is nonzero, or during CHECK, are dropped, not queued. The counter decrements to 0 each cycle.
  - Start edges in PLAY are ignored.
- Goal: in the cycle after a commit that lands on (num-2, num-2), go to WIN and assert win_pulse for exactly one cycle.
- WIN (2):
  - Position, map, num and step_count are held.
  - On start edge: go to WELCOME. Latched num/map are held until the next valid start.
- num/map outputs change only on an accepted start, so the drawer never sees a mid-game map change.

Test Plan:
- Reset, then start with num_in=7, open 7x7 map with border walls -> state 0 then 1 after start edge; x=y=1; step_count=0.
- Right edge at (1,1), open cell -> x=2 exactly 2 cycles after the edge fires; step_count=1; a second right edge 3 cycles later (MOVE_GAP=8) is dropped and x stays 2.
- Up edge at (1,1) with wall at y=0 -> x=y=1, bump_pulse high for one cycle, step_count unchanged; same for left into x=0 with the border wall removed (bounds check only).
- Up and right edges in the same cycle at (1,1) with (1,0) wall -> up is chosen, bump_pulse asserted, right is not tried.
- Walk to (5,5) in the 7x7 map -> state=2 one cycle after the commit, win_pulse high exactly one cycle; start edge -> state=0; start with num_in=4 -> stays 0, num stays 7.
- Assert rst_sys during CHECK cycle -> outputs return to reset values immediately (async), no commit after release.

Source files
------------

// File: rtl/maze_game_ctrl.sv
// Maze game controller: conditions buttons, sequences welcome/play/win and
// validates each move against maze bounds and walls before committing it.
module maze_game_ctrl #(
  parameter int unsigned MOVE_GAP = 2500000,
  parameter int unsigned MIN_NUM  = 5,
  parameter int unsigned MAX_NUM  = 19
) (
  input  logic         vga_clk,
  input  logic         rst_sys,
  input  logic         btn_start,
  input  logic         btn_up,
  input  logic         btn_down,
  input  logic         btn_left,
  input  logic         btn_right,
  input  logic [4:0]   num_in,
  input  logic [360:0] map_in,
  output logic [1:0]   state,
  output logic [4:0]   num,
  output logic [360:0] map,
  output logic [4:0]   x_index,
  output logic [4:0]   y_index,
  output logic [9:0]   step_count,
  output logic         win_pulse,
  output logic         bump_pulse
);

  localparam int unsigned NUM_W    = 5;
  localparam int unsigned POS_W    = 5;
  localparam int unsigned STEP_W   = 10;
  localparam int unsigned IDX_W    = 9;
  localparam int unsigned PROD_W   = 10;
  localparam int unsigned BTN_W    = 5;
  localparam int unsigned STEP_MAX = 1023;
  localparam int unsigned GAP_W    = (MOVE_GAP > 0) ? $clog2(MOVE_GAP + 1) : 1;

  // CHECK is the second half of a move inside PLAY; it reports as PLAY.
  typedef enum logic [1:0] {
    S_WELCOME = 2'd0,
    S_PLAY    = 2'd1,
    S_WIN     = 2'd2,
    S_CHECK   = 2'd3
  } st_t;

  st_t                     st, st_nx;
  logic [BTN_W-1:0]        sync1, sync2, prev;
  logic [BTN_W-1:0]        edge_c;
  logic [1:0]              state_nx;
  logic [NUM_W-1:0]        num_nx;
  logic [360:0]            map_nx;
  logic [POS_W-1:0]        x_nx, y_nx;
  logic signed [POS_W:0]   tx, ty, tx_nx, ty_nx;
  logic signed [POS_W:0]   x_s_c, y_s_c, num_s_c;
  logic [STEP_W-1:0]       step_nx;
  logic                    win_nx, bump_nx;
  logic [GAP_W-1:0]        gap, gap_nx;
  logic [PROD_W-1:0]       prod_c;
  logic [IDX_W-1:0]        wall_idx_c;
  logic                    in_bounds_c, legal_c, goal_c, num_ok_c;

  // Edge bits: [4] start, [3] up, [2] down, [1] left, [0] right.
  assign edge_c = sync2 & ~prev;

  always_ff @(posedge vga_clk or posedge rst_sys) begin
    if (rst_sys) begin
      sync1      <= '0;
      sync2      <= '0;
      prev       <= '0;
      st         <= S_WELCOME;
      state      <= 2'd0;
      num        <= '0;
      map        <= '0;
      x_index    <= POS_W'(1);
      y_index    <= POS_W'(1);
      tx         <= '0;
      ty         <= '0;
      step_count <= '0;
      win_pulse  <= 1'b0;
      bump_pulse <= 1'b0;
      gap        <= '0;
    end else begin
      sync1      <= {btn_start, btn_up, btn_down, btn_left, btn_right};
      sync2      <= sync1;
      prev       <= sync2;
      st         <= st_nx;
      state      <= state_nx;
      num        <= num_nx;
      map        <= map_nx;
      x_index    <= x_nx;
      y_index    <= y_nx;
      tx         <= tx_nx;
      ty         <= ty_nx;
      step_count <= step_nx;
      win_pulse  <= win_nx;
      bump_pulse <= bump_nx;
      gap        <= gap_nx;
    end
  end

  // Signed 6-bit target so that a step off the low edge shows up as -1.
  always_comb begin
    x_s_c       = signed'({1'b0, x_index});
    y_s_c       = signed'({1'b0, y_index});
    num_s_c     = signed'({1'b0, num});
    in_bounds_c = (tx >= 6'sd0) && (ty >= 6'sd0) && (tx < num_s_c) && (ty < num_s_c);
    prod_c      = PROD_W'(ty[POS_W-1:0]) * PROD_W'(num) + PROD_W'(tx[POS_W-1:0]);
    wall_idx_c  = IDX_W'(prod_c);
    legal_c     = in_bounds_c && !map[wall_idx_c];
    goal_c      = (tx[POS_W-1:0] == num - NUM_W'(2)) && (ty[POS_W-1:0] == num - NUM_W'(2));
    num_ok_c    = (num_in >= NUM_W'(MIN_NUM)) && (num_in <= NUM_W'(MAX_NUM));
  end

  always_comb begin
    st_nx   = st;
    num_nx  = num;
    map_nx  = map;
    x_nx    = x_index;
    y_nx    = y_index;
    tx_nx   = tx;
    ty_nx   = ty;
    step_nx = step_count;
    win_nx  = 1'b0;
    bump_nx = 1'b0;
    gap_nx  = (gap != '0) ? gap - GAP_W'(1) : '0;

    case (st)
      S_WELCOME: begin
        if (edge_c[4] && num_ok_c) begin
          num_nx  = num_in;
          map_nx  = map_in;
          x_nx    = POS_W'(1);
          y_nx    = POS_W'(1);
          step_nx = '0;
          st_nx   = S_PLAY;
        end
      end
      S_PLAY: begin
        if ((gap == '0) && (|edge_c[3:0])) begin
          tx_nx = x_s_c;
          ty_nx = y_s_c;
          if (edge_c[3])      ty_nx = y_s_c - 6'sd1;
          else if (edge_c[2]) ty_nx = y_s_c + 6'sd1;
          else if (edge_c[1]) tx_nx = x_s_c - 6'sd1;
          else                tx_nx = x_s_c + 6'sd1;
          st_nx = S_CHECK;
        end
      end
      S_CHECK: begin
        gap_nx = GAP_W'(MOVE_GAP);
        st_nx  = S_PLAY;
        if (legal_c) begin
          x_nx    = tx[POS_W-1:0];
          y_nx    = ty[POS_W-1:0];
          step_nx = (step_count == STEP_W'(STEP_MAX)) ? step_count : step_count + STEP_W'(1);
          if (goal_c) begin
            st_nx  = S_WIN;
            win_nx = 1'b1;
          end
        end else begin
          bump_nx = 1'b1;
        end
      end
      S_WIN: begin
        if (edge_c[4]) st_nx = S_WELCOME;
      end
      default: st_nx = S_WELCOME;
    endcase

    state_nx = (st_nx == S_CHECK) ? 2'd1 : 2'(st_nx);
  end

endmodule

// File: tb/tb_maze_game_ctrl.sv
// Scoreboard bench for maze_game_ctrl: a small maze model predicts each move
// outcome, which is queued at stimulus time and compared at commit time.
module tb_maze_game_ctrl;

  localparam int unsigned GAP = 8;

  logic         vga_clk = 1'b0;
  logic         rst_sys;
  logic         btn_start, btn_up, btn_down, btn_left, btn_right;
  logic [4:0]   num_in;
  logic [360:0] map_in;
  logic [1:0]   state;
  logic [4:0]   num;
  logic [360:0] map;
  logic [4:0]   x_index, y_index;
  logic [9:0]   step_count;
  logic         win_pulse, bump_pulse;

  maze_game_ctrl #(.MOVE_GAP(GAP), .MIN_NUM(5), .MAX_NUM(19)) dut (
    .vga_clk    (vga_clk),
    .rst_sys    (rst_sys),
    .btn_start  (btn_start),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .num_in     (num_in),
    .map_in     (map_in),
    .state      (state),
    .num        (num),
    .map        (map),
    .x_index    (x_index),
    .y_index    (y_index),
    .step_count (step_count),
    .win_pulse  (win_pulse),
    .bump_pulse (bump_pulse)
  );

  always #5 vga_clk = ~vga_clk;

  // Observed/expected tuple: state, x, y, step, bump, win.
  typedef struct packed {
    logic [1:0] st;
    logic [4:0] x;
    logic [4:0] y;
    logic [9:0] step;
    logic       bump;
    logic       win;
  } obs_t;

  localparam logic [3:0] UP = 4'b1000, DOWN = 4'b0100, LEFT = 4'b0010, RIGHT = 4'b0001;

  int total = 0;
  int bad = 0;
  obs_t sb_q[$];

  int           mx, my, mstep, mnum;
  logic [1:0]   mst;
  logic [360:0] mmap;

  function automatic obs_t observe();
    return obs_t'({state, x_index, y_index, step_count, bump_pulse, win_pulse});
  endfunction

  function automatic obs_t model_now(input bit bump, input bit win);
    return obs_t'({mst, 5'(mx), 5'(my), 10'(mstep), bump, win});
  endfunction

  function automatic logic [360:0] make_map(input int n, input bit open_left);
    logic [360:0] m;
    m = '0;
    for (int yy = 0; yy < n; yy++)
      for (int xx = 0; xx < n; xx++)
        if (xx == 0 || yy == 0 || xx == n - 1 || yy == n - 1) m[yy * n + xx] = 1'b1;
    if (open_left) m[n] = 1'b0;
    return m;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge vga_clk);
  endtask

  task automatic apply_reset();
    rst_sys = 1'b1;
    {btn_start, btn_up, btn_down, btn_left, btn_right} = '0;
    tick(2);
    rst_sys = 1'b0;
    tick(1);
    mx = 1; my = 1; mstep = 0; mnum = 0; mst = 2'd0; mmap = '0;
  endtask

  task automatic press_start(input logic [4:0] n, input logic [360:0] m);
    bit accept;
    accept = (n >= 5) && (n <= 19);
    num_in = n; map_in = m; btn_start = 1'b1;
    tick(2);
    total++;
    if (state !== 2'd0) begin
      bad++; $display("FAIL start_pre_edge: state got %0d want 0", state);
    end
    tick(1);
    btn_start = 1'b0;
    if (accept) begin
      mx = 1; my = 1; mstep = 0; mnum = n; mst = 2'd1; mmap = m;
    end
    total++;
    if ({observe(), num} !== {model_now(1'b0, 1'b0), 5'(mnum)}) begin
      bad++;
      $display("FAIL start_latch n=%0d: got %h num=%0d want %h num=%0d",
               n, observe(), num, model_now(1'b0, 1'b0), mnum);
    end
    if (accept) begin
      total++;
      if (map !== m) begin bad++; $display("FAIL start_map: latched map differs from map_in"); end
    end
    tick(2);
  endtask

  task automatic start_game(input int n, input bit open_left);
    apply_reset();
    press_start(5'(n), make_map(n, open_left));
  endtask

  // Drives one move, queues the model's prediction, checks it at commit time.
  task automatic move(input logic [3:0] dir, input int settle);
    int tx, ty;
    bit legal, goal;
    obs_t e, o;
    tx = mx; ty = my;
    if (dir[3])      ty = my - 1;
    else if (dir[2]) ty = my + 1;
    else if (dir[1]) tx = mx - 1;
    else             tx = mx + 1;
    legal = (tx >= 0) && (ty >= 0) && (tx < mnum) && (ty < mnum);
    if (legal) legal = (mmap[ty * mnum + tx] == 1'b0);
    goal = legal && (tx == mnum - 2) && (ty == mnum - 2);
    if (legal)
      e = obs_t'({goal ? 2'd2 : 2'd1, 5'(tx), 5'(ty),
                  10'((mstep == 1023) ? mstep : mstep + 1), 1'b0, goal});
    else
      e = obs_t'({2'd1, 5'(mx), 5'(my), 10'(mstep), 1'b1, 1'b0});
    sb_q.push_back(e);

    {btn_up, btn_down, btn_left, btn_right} = dir;
    tick(3);
    total++;
    if (observe() !== model_now(1'b0, 1'b0)) begin
      bad++; $display("FAIL move_precommit dir=%b: got %h want %h", dir, observe(), model_now(1'b0, 1'b0));
    end
    tick(1);
    {btn_up, btn_down, btn_left, btn_right} = '0;
    o = observe();
    e = sb_q.pop_front();
    total++;
    if (o !== e) begin
      bad++; $display("FAIL move_commit dir=%b: got %h want %h", dir, o, e);
    end
    mx = e.x; my = e.y; mstep = e.step; mst = e.st;
    tick(1);
    total++;
    if (observe() !== model_now(1'b0, 1'b0)) begin
      bad++; $display("FAIL move_pulse_clear dir=%b: got %h want %h", dir, observe(), model_now(1'b0, 1'b0));
    end
    tick(settle);
  endtask

  task automatic test_reset();
    btn_start = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    num_in = '0; map_in = '0;
    apply_reset();
    total++;
    if ({observe(), num} !== {obs_t'({2'd0, 5'd1, 5'd1, 10'd0, 1'b0, 1'b0}), 5'd0}) begin
      bad++; $display("FAIL reset_values: got %h num=%0d", observe(), num);
    end
    total++;
    if (map !== '0) begin bad++; $display("FAIL reset_map: map nonzero after reset"); end
  endtask

  task automatic test_start();
    start_game(7, 1'b0);
  endtask

  task automatic test_move_and_gap();
    move(RIGHT, 0);
    btn_right = 1'b1;
    tick(5);
    btn_right = 1'b0;
    total++;
    if (observe() !== model_now(1'b0, 1'b0)) begin
      bad++; $display("FAIL gap_drop: got %h want %h", observe(), model_now(1'b0, 1'b0));
    end
    tick(GAP + 2);
  endtask

  task automatic test_wall_bump();
    move(LEFT, GAP + 2);
    move(UP, GAP + 2);
  endtask

  task automatic test_priority();
    move(UP | RIGHT, GAP + 2);
  endtask

  task automatic test_bounds();
    start_game(7, 1'b1);
    move(LEFT, GAP + 2);
    move(LEFT, GAP + 2);
  endtask

  task automatic test_win();
    start_game(7, 1'b0);
    for (int i = 0; i < 4; i++) move(RIGHT, GAP + 2);
    for (int i = 0; i < 4; i++) move(DOWN, GAP + 2);
    total++;
    if (state !== 2'd2) begin bad++; $display("FAIL win_hold: state got %0d want 2", state); end
    btn_start = 1'b1;
    tick(3);
    btn_start = 1'b0;
    total++;
    if ({state, num} !== {2'd0, 5'd7}) begin
      bad++; $display("FAIL win_to_welcome: state=%0d num=%0d want 0/7", state, num);
    end
    mst = 2'd0;
    tick(2);
    press_start(5'd4, make_map(4, 1'b0));
  endtask

  task automatic test_reset_mid_check();
    start_game(7, 1'b0);
    btn_right = 1'b1;
    tick(3);
    rst_sys = 1'b1;
    #1;
    total++;
    if ({observe(), num} !== {obs_t'({2'd0, 5'd1, 5'd1, 10'd0, 1'b0, 1'b0}), 5'd0}) begin
      bad++; $display("FAIL reset_async: got %h num=%0d", observe(), num);
    end
    tick(1);
    btn_right = 1'b0;
    rst_sys = 1'b0;
    tick(4);
    total++;
    if ({observe(), num} !== {obs_t'({2'd0, 5'd1, 5'd1, 10'd0, 1'b0, 1'b0}), 5'd0}) begin
      bad++; $display("FAIL reset_no_commit: got %h num=%0d", observe(), num);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_move_and_gap();
    test_wall_bump();
    test_priority();
    test_bounds();
    test_win();
    test_reset_mid_check();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
